// File: rtl/alu_issue_stage.sv
// alu_issue_stage: single-slot issue stage in front of a combinational ALU.
// It accepts one operation, drives the ALU for EXEC and FLAG, and captures
// the result and flags into output registers on entry to DONE.
// Illegal opcodes (1110, 1111) skip the ALU and return an error result after
// one cycle.
// Optional feature macro: ALU_DIVZERO_TRAP_EN -- when defined, DIV (1001)
// with a zero divisor takes the error path instead of reaching the ALU.
module alu_issue_stage #(
  parameter int RD_W = 5
) (
  input  logic            clockAuto,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      in_controle,
  input  logic [31:0]     in_dado1,
  input  logic [31:0]     in_dado2,
  input  logic [RD_W-1:0] in_rd,
  output logic [31:0]     alu_dado1,
  output logic [31:0]     alu_dado2,
  output logic [3:0]      alu_controle,
  input  logic [31:0]     alu_saida,
  input  logic            alu_sinal_ZERO,
  input  logic            alu_sinal_NEG,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_resultado,
  output logic [RD_W-1:0] out_rd,
  output logic            out_zero,
  output logic            out_neg,
  output logic            out_erro
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    FLAG = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [3:0] OP_MOV = 4'b0100;
  localparam logic [3:0] OP_DIV = 4'b1001;

  state_t state_reg;
  state_t state_next;

  // Operand registers feeding the ALU.
  logic [3:0]      ctrl_reg;
  logic [31:0]     dado1_reg;
  logic [31:0]     dado2_reg;
  logic [RD_W-1:0] rd_reg;

  // Result registers presented downstream.
  logic [31:0]     res_reg;
  logic [RD_W-1:0] out_rd_reg;
  logic            zero_reg;
  logic            neg_reg;
  logic            erro_reg;

  logic accept;
  logic illegal_op;
  logic trap_op;
  logic bad_op;

  assign accept     = in_valid & in_ready;
  assign illegal_op = (in_controle[3:1] == 3'b111);

`ifdef ALU_DIVZERO_TRAP_EN
  assign trap_op = (in_controle == OP_DIV) && (in_dado2 == 32'd0);
`else
  assign trap_op = 1'b0;
`endif

  // Any operation that must never reach the ALU goes straight to DONE.
  assign bad_op = illegal_op | trap_op;

  // State register; reset wins over every handshake.
  always_ff @(posedge clockAuto) begin
    if (reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = bad_op ? DONE : EXEC;
        end
      end
      EXEC: state_next = FLAG;
      FLAG: state_next = DONE;
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_next = bad_op ? DONE : EXEC;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Handshake and ALU-control outputs decoded from the current state.
  always_comb begin
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    alu_controle = OP_MOV;
    case (state_reg)
      IDLE: in_ready = 1'b1;
      EXEC: alu_controle = ctrl_reg;
      FLAG: alu_controle = ctrl_reg;
      DONE: begin
        in_ready  = out_ready;
        out_valid = 1'b1;
      end
      default: begin
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        alu_controle = OP_MOV;
      end
    endcase
  end

  // Operand capture on accept and result capture on FLAG->DONE or error path.
  always_ff @(posedge clockAuto) begin
    if (reset) begin
      ctrl_reg   <= 4'd0;
      dado1_reg  <= 32'd0;
      dado2_reg  <= 32'd0;
      rd_reg     <= '0;
      res_reg    <= 32'd0;
      out_rd_reg <= '0;
      zero_reg   <= 1'b0;
      neg_reg    <= 1'b0;
      erro_reg   <= 1'b0;
    end else begin
      if (accept) begin
        ctrl_reg  <= in_controle;
        dado1_reg <= in_dado1;
        dado2_reg <= in_dado2;
        rd_reg    <= in_rd;
      end
      if (accept && bad_op) begin
        // Trapped divide reports all-ones/negative; illegal opcode reports zero.
        res_reg    <= trap_op ? 32'hFFFF_FFFF : 32'd0;
        out_rd_reg <= in_rd;
        zero_reg   <= ~trap_op;
        neg_reg    <= trap_op;
        erro_reg   <= 1'b1;
      end else if (state_reg == FLAG) begin
        // Flags were registered by the ALU at EXEC->FLAG; result is still settled.
        res_reg    <= alu_saida;
        out_rd_reg <= rd_reg;
        zero_reg   <= alu_sinal_ZERO;
        neg_reg    <= alu_sinal_NEG;
        erro_reg   <= 1'b0;
      end
    end
  end

  assign alu_dado1     = dado1_reg;
  assign alu_dado2     = dado2_reg;
  assign out_resultado = res_reg;
  assign out_rd        = out_rd_reg;
  assign out_zero      = zero_reg;
  assign out_neg       = neg_reg;
  assign out_erro      = erro_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed bench for alu_issue_stage with a small
// behavioural ALU (combinational result, flags registered one clock later).
module tb_alu_issue_stage;

  localparam int RD_W = 5;

  logic            clk;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [3:0]      in_controle;
  logic [31:0]     in_dado1;
  logic [31:0]     in_dado2;
  logic [RD_W-1:0] in_rd;
  logic [31:0]     alu_dado1;
  logic [31:0]     alu_dado2;
  logic [3:0]      alu_controle;
  logic [31:0]     alu_saida;
  logic            alu_zero;
  logic            alu_neg;
  logic            out_valid;
  logic            out_ready;
  logic [31:0]     out_resultado;
  logic [RD_W-1:0] out_rd;
  logic            out_zero;
  logic            out_neg;
  logic            out_erro;

  int checks = 0;
  int errors = 0;

  alu_issue_stage #(.RD_W(RD_W)) dut (
    .clockAuto     (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_controle   (in_controle),
    .in_dado1      (in_dado1),
    .in_dado2      (in_dado2),
    .in_rd         (in_rd),
    .alu_dado1     (alu_dado1),
    .alu_dado2     (alu_dado2),
    .alu_controle  (alu_controle),
    .alu_saida     (alu_saida),
    .alu_sinal_ZERO(alu_zero),
    .alu_sinal_NEG (alu_neg),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_resultado (out_resultado),
    .out_rd        (out_rd),
    .out_zero      (out_zero),
    .out_neg       (out_neg),
    .out_erro      (out_erro)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU: divide by zero returns a recognisable marker.
  always_comb begin
    alu_saida = 32'd0;
    case (alu_controle)
      4'b0000: alu_saida = alu_dado1 + alu_dado2;
      4'b0001: alu_saida = alu_dado1 - alu_dado2;
      4'b0100: alu_saida = alu_dado2;
      4'b1001: alu_saida = (alu_dado2 == 32'd0) ? 32'hDEAD_BEEF : alu_dado1 / alu_dado2;
      default: alu_saida = 32'd0;
    endcase
  end

  // ALU flags lag the result by one clock.
  always_ff @(posedge clk) begin
    alu_zero <= (alu_saida == 32'd0);
    alu_neg  <= alu_saida[31];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [RD_W-1:0] rd);
    in_valid    = 1'b1;
    in_controle = op;
    in_dado1    = a;
    in_dado2    = b;
    in_rd       = rd;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_controle = 4'd0; in_dado1 = 32'd0; in_dado2 = 32'd0; in_rd = '0;
    tick(); tick();
    reset = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
    checks++; if (out_resultado !== 32'd0) begin errors++; $display("FAIL reset_resultado got %h exp 0", out_resultado); end
    checks++; if ({out_rd, out_zero, out_neg, out_erro} !== '0) begin errors++; $display("FAIL reset_rd_flags got rd=%0d z=%0b n=%0b e=%0b exp all 0", out_rd, out_zero, out_neg, out_erro); end
    checks++; if (alu_controle !== 4'b0100) begin errors++; $display("FAIL reset_alu_ctrl got %b exp 0100", alu_controle); end
    checks++; if ({alu_dado1, alu_dado2} !== 64'd0) begin errors++; $display("FAIL reset_operands got %h %h exp 0 0", alu_dado1, alu_dado2); end
    $display("txn reset: out_valid=%0b in_ready=%0b", out_valid, in_ready);
  endtask

  task automatic test_add();
    out_ready = 1'b1;
    drive_op(4'b0000, 32'd5, 32'd7, 5'd3);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL add_exec_hs got v=%0b r=%0b exp 0 0", out_valid, in_ready); end
    checks++; if (alu_controle !== 4'b0000 || alu_dado1 !== 32'd5 || alu_dado2 !== 32'd7) begin errors++; $display("FAIL add_exec_alu got %b %0d %0d exp 0000 5 7", alu_controle, alu_dado1, alu_dado2); end
    tick();
    checks++; if (out_valid !== 1'b0 || alu_controle !== 4'b0000 || alu_dado2 !== 32'd7) begin errors++; $display("FAIL add_flag got v=%0b ctl=%b b=%0d exp 0 0000 7", out_valid, alu_controle, alu_dado2); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency got out_valid=%0b exp 1", out_valid); end
    checks++; if (out_resultado !== 32'd12 || out_rd !== 5'd3) begin errors++; $display("FAIL add_result got %0d rd=%0d exp 12 rd=3", out_resultado, out_rd); end
    checks++; if ({out_zero, out_neg, out_erro} !== 3'b000) begin errors++; $display("FAIL add_flags got z=%0b n=%0b e=%0b exp 0 0 0", out_zero, out_neg, out_erro); end
    checks++; if (alu_controle !== 4'b0100) begin errors++; $display("FAIL add_done_ctrl got %b exp 0100", alu_controle); end
    $display("txn add 5+7 rd=3 -> %0d", out_resultado);
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_idle got v=%0b r=%0b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_sub();
    out_ready = 1'b1;
    drive_op(4'b0001, 32'd3, 32'd5, 5'd1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_resultado !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_neg_result got v=%0b %h exp 1 fffffffe", out_valid, out_resultado); end
    checks++; if ({out_zero, out_neg, out_erro} !== 3'b010) begin errors++; $display("FAIL sub_neg_flags got z=%0b n=%0b e=%0b exp 0 1 0", out_zero, out_neg, out_erro); end
    $display("txn sub 3-5 rd=1 -> %h", out_resultado);
    tick();
    drive_op(4'b0001, 32'd9, 32'd9, 5'd2);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_resultado !== 32'd0 || out_rd !== 5'd2) begin errors++; $display("FAIL sub_zero_result got v=%0b %h rd=%0d exp 1 0 rd=2", out_valid, out_resultado, out_rd); end
    checks++; if ({out_zero, out_neg, out_erro} !== 3'b100) begin errors++; $display("FAIL sub_zero_flags got z=%0b n=%0b e=%0b exp 1 0 0", out_zero, out_neg, out_erro); end
    $display("txn sub 9-9 rd=2 -> %h", out_resultado);
    tick();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    drive_op(4'b0000, 32'd1, 32'd2, 5'd4);
    tick();
    // Offer the next op while the stage is busy and then stalled.
    drive_op(4'b0001, 32'd10, 32'd4, 5'd5);
    tick(); tick();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_resultado !== 32'd3 || out_rd !== 5'd4 || in_ready !== 1'b0 ||
          {out_zero, out_neg, out_erro} !== 3'b000) begin
        errors++;
        $display("FAIL stall_hold[%0d] got v=%0b res=%0d rd=%0d r=%0b zne=%b exp 1 3 4 0 000",
                 i, out_valid, out_resultado, out_rd, in_ready, {out_zero, out_neg, out_erro});
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %0b exp 1", in_ready); end
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || alu_controle !== 4'b0001 || alu_dado1 !== 32'd10) begin errors++; $display("FAIL b2b_accept got v=%0b ctl=%b a=%0d exp 0 0001 10", out_valid, alu_controle, alu_dado1); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_early got out_valid=%0b exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1 || out_resultado !== 32'd6 || out_rd !== 5'd5) begin errors++; $display("FAIL b2b_result got v=%0b %0d rd=%0d exp 1 6 rd=5", out_valid, out_resultado, out_rd); end
    $display("txn stall add 1+2 then sub 10-4 rd=5 -> %0d", out_resultado);
    tick();
  endtask

  task automatic test_illegal();
    out_ready = 1'b1;
    drive_op(4'b1111, 32'd7, 32'd8, 5'd6);
    tick();
    checks++; if (out_valid !== 1'b1 || out_erro !== 1'b1) begin errors++; $display("FAIL ill_latency got v=%0b e=%0b exp 1 1", out_valid, out_erro); end
    checks++; if (out_resultado !== 32'd0 || out_zero !== 1'b1 || out_neg !== 1'b0 || out_rd !== 5'd6) begin errors++; $display("FAIL ill_result got %h z=%0b n=%0b rd=%0d exp 0 1 0 6", out_resultado, out_zero, out_neg, out_rd); end
    checks++; if (alu_controle !== 4'b0100) begin errors++; $display("FAIL ill_alu_ctrl got %b exp 0100", alu_controle); end
    $display("txn illegal 1111 rd=6 -> erro=%0b", out_erro);
    // Back-to-back illegal op replaces the result without leaving DONE.
    drive_op(4'b1110, 32'd1, 32'd1, 5'd7);
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_rd !== 5'd7 || out_erro !== 1'b1 || alu_controle !== 4'b0100) begin errors++; $display("FAIL ill_b2b got v=%0b rd=%0d e=%0b ctl=%b exp 1 7 1 0100", out_valid, out_rd, out_erro, alu_controle); end
    $display("txn illegal 1110 rd=7 -> erro=%0b", out_erro);
    tick();
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL ill_idle got v=%0b r=%0b exp 0 1", out_valid, in_ready); end
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1;
    drive_op(4'b0000, 32'd100, 32'd200, 5'd9);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (alu_controle !== 4'b0000 || in_ready !== 1'b0) begin errors++; $display("FAIL abort_in_flag got ctl=%b r=%0b exp 0000 0", alu_controle, in_ready); end
    // Reset during FLAG, with a competing new op and out_ready both high.
    reset = 1'b1;
    drive_op(4'b0000, 32'd11, 32'd22, 5'd10);
    tick();
    reset = 1'b0;
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_idle got v=%0b r=%0b exp 0 1", out_valid, in_ready); end
    checks++; if (alu_dado1 !== 32'd0 || alu_controle !== 4'b0100 || out_rd !== 5'd0) begin errors++; $display("FAIL abort_cleared got a=%0d ctl=%b rd=%0d exp 0 0100 0", alu_dado1, alu_controle, out_rd); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL abort_no_result[%0d] got out_valid=%0b exp 0", i, out_valid); end
    end
    $display("txn reset during FLAG: aborted add 100+200");
  endtask

  task automatic test_divzero();
    out_ready = 1'b1;
    drive_op(4'b1001, 32'd10, 32'd0, 5'd8);
    tick();
    in_valid = 1'b0;
`ifdef ALU_DIVZERO_TRAP_EN
    checks++; if (out_valid !== 1'b1 || out_resultado !== 32'hFFFF_FFFF || out_erro !== 1'b1) begin errors++; $display("FAIL div0_trap got v=%0b %h e=%0b exp 1 ffffffff 1", out_valid, out_resultado, out_erro); end
    checks++; if (out_zero !== 1'b0 || out_neg !== 1'b1 || out_rd !== 5'd8 || alu_controle !== 4'b0100) begin errors++; $display("FAIL div0_trap_flags got z=%0b n=%0b rd=%0d ctl=%b exp 0 1 8 0100", out_zero, out_neg, out_rd, alu_controle); end
`else
    checks++; if (out_valid !== 1'b0 || alu_controle !== 4'b1001) begin errors++; $display("FAIL div0_exec got v=%0b ctl=%b exp 0 1001", out_valid, alu_controle); end
    tick(); tick();
    checks++; if (out_valid !== 1'b1 || out_resultado !== 32'hDEAD_BEEF || out_erro !== 1'b0) begin errors++; $display("FAIL div0_normal got v=%0b %h e=%0b exp 1 deadbeef 0", out_valid, out_resultado, out_erro); end
    checks++; if (out_zero !== 1'b0 || out_neg !== 1'b1 || out_rd !== 5'd8) begin errors++; $display("FAIL div0_normal_flags got z=%0b n=%0b rd=%0d exp 0 1 8", out_zero, out_neg, out_rd); end
`endif
    $display("txn div 10/0 rd=8 -> %h erro=%0b", out_resultado, out_erro);
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_back_to_back();
    test_illegal();
    test_reset_abort();
    test_divzero();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

Interface
REQ-001 Parameter RD_W, default 5: destination-register tag width.
REQ-002 clockAuto  in  1  sole clock; all state updates on posedge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on posedge clockAuto.
REQ-004 in_valid  in  1  upstream operation valid.
REQ-005 in_ready  out  1  stage can accept an operation this cycle.
REQ-006 in_controle  in  4  ALU opcode (0000 ADD .. 1101 EQ).
REQ-007 in_dado1, in_dado2  in  32 each  operands.
REQ-008 in_rd  in  RD_W  destination tag, carried through unchanged.
REQ-009 alu_dado1, alu_dado2  out  32 each  operands driven to the ALU.
REQ-010 alu_controle  out  4  opcode driven to the ALU.
REQ-011 alu_saida  in  32  combinational ALU result.
REQ-012 alu_sinal_ZERO, alu_sinal_NEG  in  1 each  ALU flags, registered inside the ALU one clock after alu_saida settles.
REQ-013 out_valid  out  1  result valid downstream.
REQ-014 out_ready  in  1  downstream accepts the result.
REQ-015 out_resultado  out  32; out_rd  out  RD_W; out_zero, out_neg, out_erro  out  1 each.

Function
REQ-016 The stage SHALL implement FSM states IDLE, EXEC, FLAG, DONE.
REQ-017 in_ready SHALL be 1 in IDLE, and in DONE only when out_ready=1; 0 in EXEC and FLAG.
REQ-018 Accept (in_valid & in_ready) SHALL latch in_controle, in_dado1, in_dado2, in_rd into operand registers.
REQ-019 An accepted legal opcode (0000-1101) SHALL move to EXEC; EXEC SHALL always move to FLAG; FLAG SHALL always move to DONE.
REQ-020 alu_dado1, alu_dado2, alu_controle SHALL be driven from the operand registers and held stable throughout EXEC and FLAG.
REQ-021 At the FLAG->DONE edge the stage SHALL capture alu_saida into out_resultado, alu_sinal_ZERO into out_zero, and alu_sinal_NEG into out_neg; out_erro SHALL be 0.
REQ-022 Latency SHALL be exactly 3 cycles: accept at edge N; out_valid=1 from cycle N+3.
REQ-023 out_valid SHALL be 1 only in DONE; out_resultado, out_rd, out_zero, out_neg, out_erro SHALL be held constant while out_valid=1 and out_ready=0.
REQ-024 DONE with out_ready=1 and in_valid=0 SHALL go to IDLE.
REQ-025 DONE with out_ready=1 and in_valid=1 SHALL complete the handoff and accept the new operation on the same edge, going to EXEC (back-to-back throughput: one op per 3 cycles).
REQ-026 An accepted illegal opcode (1110, 1111) SHALL bypass EXEC and FLAG and go directly to DONE, with out_resultado=0, out_zero=1, out_neg=0, out_erro=1 (latency 1 cycle).
REQ-027 alu_controle SHALL be driven to 0100 (MOV) whenever the state is IDLE or DONE, so the ALU never sees an illegal opcode.

Reset
REQ-028 reset=1 at a posedge SHALL force IDLE from any state, including mid-EXEC or FLAG, discarding the in-flight operation.
REQ-029 After reset: out_valid=0, out_resultado=0, out_rd=0, out_zero=0, out_neg=0, out_erro=0, operand registers=0, in_ready=1.
REQ-030 reset SHALL take priority over any simultaneous in_valid or out_ready.

Configuration
REQ-031 Macro ALU_DIVZERO_TRAP_EN: when defined, an accepted opcode 1001 with in_dado2=0 SHALL take the illegal-opcode path (direct to DONE, out_resultado=32'hFFFFFFFF, out_zero=0, out_neg=1, out_erro=1), and the ALU SHALL never be driven with that division.
REQ-032 When ALU_DIVZERO_TRAP_EN is not defined, divide-by-zero SHALL follow the normal 3-cycle path, and out_resultado SHALL be whatever value alu_saida presents.

Verification
REQ-033 ADD 5+7, rd=3, out_ready=1 -> out_valid at cycle N+3 with out_resultado=12, out_rd=3, out_zero=0, out_neg=0, out_erro=0.
REQ-034 SUB 3-5 -> out_resultado=32'hFFFFFFFE, out_neg=1; SUB 9-9 -> out_resultado=0, out_zero=1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> outputs stable and in_ready=0; then out_ready=1 with in_valid=1 -> next op accepted on the same edge, with its result 3 cycles later.
REQ-036 Opcode 1111 -> out_valid one cycle after accept, out_erro=1, out_resultado=0, out_zero=1.
REQ-037 reset asserted during FLAG -> next cycle IDLE, out_valid=0, in_ready=1, and no result ever emitted for the aborted op.
REQ-038 DIV 10/0 -> with ALU_DIVZERO_TRAP_EN: out_resultado=32'hFFFFFFFF, out_erro=1 after 1 cycle; without the macro: 3-cycle latency and out_erro=0.
